// File: rtl/keyboard_to_lcd_top.sv
// PS/2 keyboard to 16x2 HD44780 LCD bridge (4-bit, write-only).
// Optional: define PS2_PARITY_CHECK_EN to drop frames with bad odd parity.
module keyboard_to_lcd_top #(
  parameter int CLK_HZ            = 100_000_000,
  parameter int TIMEOUT_CYCLES    = 2_000_000,
  parameter int E_HIGH_CYCLES     = 25,
  parameter int CMD_WAIT_CYCLES   = 4_000,
  parameter int CLEAR_WAIT_CYCLES = 200_000
) (
  input  logic       Clock_100MHz,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:4] LCD_DB,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       Caps_Lock,
  output logic       Shift_on
);

  localparam int GAP_CYCLES =
    (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;

  localparam logic [21:0] TO_MAX   = 22'(TIMEOUT_CYCLES);
  localparam logic [21:0] PWR_LAST = 22'(TIMEOUT_CYCLES - 1);
  localparam logic [21:0] EHI_LAST = 22'(E_HIGH_CYCLES - 1);
  localparam logic [21:0] GAP_LAST = 22'(GAP_CYCLES - 1);
  localparam logic [21:0] CMD_LAST = 22'(CMD_WAIT_CYCLES - 1);
  localparam logic [21:0] CLR_LAST = 22'(CLEAR_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PWR,
    S_SETUP,
    S_EHI,
    S_HOLD,
    S_GAP,
    S_WAIT,
    S_IDLE
  } lcd_state_t;

  // ---------------- PS/2 receiver ----------------
  logic [1:0]  r_clk_sync;
  logic [1:0]  r_dat_sync;
  logic        r_clk_prev;
  logic [3:0]  r_bit_idx;
  logic [9:0]  r_frame;
  logic [21:0] r_to_cnt;
  logic        r_code_valid;
  logic [7:0]  r_code;

  logic w_ps2_clk;
  logic w_ps2_dat;
  logic w_fall;
  logic w_edge;
  logic w_frame_ok;

  assign w_ps2_clk = r_clk_sync[1];
  assign w_ps2_dat = r_dat_sync[1];
  assign w_fall    = r_clk_prev & ~w_ps2_clk;
  assign w_edge    = r_clk_prev ^ w_ps2_clk;

`ifdef PS2_PARITY_CHECK_EN
  assign w_frame_ok = ~r_frame[0] & w_ps2_dat & (^r_frame[9:1]);
`else
  logic w_unused_par;
  assign w_unused_par = r_frame[9];
  assign w_frame_ok   = ~r_frame[0] & w_ps2_dat;
`endif

  // Two-flop synchronisers; idle-high reset avoids a false edge.
  always_ff @(posedge Clock_100MHz) begin
    if (!Reset_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], PS2_CLK};
      r_dat_sync <= {r_dat_sync[0], PS2_DAT};
      r_clk_prev <= w_ps2_clk;
    end
  end

  // Frame assembly on PS2_CLK falls, with inactivity resync.
  always_ff @(posedge Clock_100MHz) begin
    if (!Reset_n) begin
      r_bit_idx    <= 4'd0;
      r_frame      <= 10'd0;
      r_to_cnt     <= 22'd0;
      r_code_valid <= 1'b0;
      r_code       <= 8'd0;
    end else begin
      r_code_valid <= 1'b0;
      if (w_edge)
        r_to_cnt <= 22'd0;
      else if (r_to_cnt != TO_MAX)
        r_to_cnt <= r_to_cnt + 22'd1;
      if (w_fall) begin
        if (r_bit_idx == 4'd10) begin
          r_bit_idx <= 4'd0;
          if (w_frame_ok) begin
            r_code_valid <= 1'b1;
            r_code       <= r_frame[8:1];
          end
        end else begin
          r_frame[r_bit_idx] <= w_ps2_dat;
          r_bit_idx          <= r_bit_idx + 4'd1;
        end
      end else if (r_to_cnt == TO_MAX) begin
        r_bit_idx <= 4'd0;
      end
    end
  end

  // ---------------- Scan-code decoder ----------------
  function automatic logic [8:0] f_ascii(
    input logic [7:0] c,
    input logic       up,
    input logic       sh
  );
    logic [7:0] l;
    logic [7:0] d;
    logic [7:0] s;
    l = 8'd0;
    d = 8'd0;
    s = 8'd0;
    case (c)
      8'h1C: l = "a";
      8'h32: l = "b";
      8'h21: l = "c";
      8'h23: l = "d";
      8'h24: l = "e";
      8'h2B: l = "f";
      8'h34: l = "g";
      8'h33: l = "h";
      8'h43: l = "i";
      8'h3B: l = "j";
      8'h42: l = "k";
      8'h4B: l = "l";
      8'h3A: l = "m";
      8'h31: l = "n";
      8'h44: l = "o";
      8'h4D: l = "p";
      8'h15: l = "q";
      8'h2D: l = "r";
      8'h1B: l = "s";
      8'h2C: l = "t";
      8'h3C: l = "u";
      8'h2A: l = "v";
      8'h1D: l = "w";
      8'h22: l = "x";
      8'h35: l = "y";
      8'h1A: l = "z";
      8'h16: begin d = "1"; s = "!"; end
      8'h1E: begin d = "2"; s = "@"; end
      8'h26: begin d = "3"; s = "#"; end
      8'h25: begin d = "4"; s = "$"; end
      8'h2E: begin d = "5"; s = "%"; end
      8'h36: begin d = "6"; s = "^"; end
      8'h3D: begin d = "7"; s = "&"; end
      8'h3E: begin d = "8"; s = "*"; end
      8'h46: begin d = "9"; s = "("; end
      8'h45: begin d = "0"; s = ")"; end
      default: ;
    endcase
    if (l != 8'd0)
      return {1'b1, up ? (l - 8'h20) : l};
    if (d != 8'd0)
      return {1'b1, sh ? s : d};
    if (c == 8'h29)
      return {1'b1, 8'h20};
    return 9'd0;
  endfunction

  logic       r_ext;
  logic       r_brk;
  logic       r_caps;
  logic       r_shift;
  logic       r_pend_v;
  logic [7:0] r_pend;

  logic [8:0] w_dec;
  logic       w_prefix;
  logic       w_new_char;
  logic       w_take;

  assign w_dec    = f_ascii(r_code, r_caps ^ r_shift, r_shift);
  assign w_prefix = (r_code == 8'hE0) | (r_code == 8'hF0);
  assign w_new_char = r_code_valid & ~w_prefix & ~r_ext
                    & ~r_brk & w_dec[8];

  assign Caps_Lock = r_caps;
  assign Shift_on  = r_shift;

  // Prefix tracking and modifier state.
  always_ff @(posedge Clock_100MHz) begin
    if (!Reset_n) begin
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_caps  <= 1'b0;
      r_shift <= 1'b0;
    end else if (r_code_valid) begin
      if (r_code == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_code == 8'hF0) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (!r_ext) begin
          if (r_code == 8'h12 || r_code == 8'h59)
            r_shift <= ~r_brk;
          else if (r_code == 8'h58 && !r_brk)
            r_caps <= ~r_caps;
        end
      end
    end
  end

  // One-entry pending buffer; a newer char overwrites.
  always_ff @(posedge Clock_100MHz) begin
    if (!Reset_n) begin
      r_pend_v <= 1'b0;
      r_pend   <= 8'd0;
    end else if (w_new_char) begin
      r_pend_v <= 1'b1;
      r_pend   <= w_dec[7:0];
    end else if (w_take) begin
      r_pend_v <= 1'b0;
    end
  end

  // ---------------- LCD sequencer ----------------
  lcd_state_t  r_state;
  lcd_state_t  w_next;
  logic [21:0] r_cnt;
  logic [7:0]  r_byte;
  logic        r_rs;
  logic        r_hi;
  logic        r_single;
  logic        r_clr;
  logic [3:0]  r_step;
  logic [1:0]  r_post;
  logic [4:0]  r_cursor;

  logic       w_done;
  logic       w_job_v;
  logic [7:0] w_job_byte;
  logic       w_job_rs;
  logic       w_job_single;
  logic       w_job_char;
  logic       w_launch;
  logic       w_in_nib;
  logic       w_in_byte;
  logic       w_run;
  logic       w_e;
  logic       w_act;
  logic [3:0] w_db;
  logic       w_rs;

  assign w_in_nib  = ~r_step[3] & ~r_step[2];
  assign w_in_byte = ~r_step[3] & r_step[2];
  assign w_run     = r_step[3];

  // Select the next write: init, cursor command, or char.
  always_comb begin
    w_job_v      = 1'b0;
    w_job_byte   = 8'd0;
    w_job_rs     = 1'b0;
    w_job_single = 1'b0;
    w_job_char   = 1'b0;
    unique case (1'b1)
      w_in_nib: begin
        w_job_v      = 1'b1;
        w_job_single = 1'b1;
        w_job_byte   = (r_step[1:0] == 2'd3) ? 8'h20 : 8'h30;
      end
      w_in_byte: begin
        w_job_v = 1'b1;
        case (r_step[1:0])
          2'd0:    w_job_byte = 8'h28;
          2'd1:    w_job_byte = 8'h0C;
          2'd2:    w_job_byte = 8'h06;
          default: w_job_byte = 8'h01;
        endcase
      end
      (w_run & (r_post != 2'd0)): begin
        w_job_v = 1'b1;
        case (r_post)
          2'd1:    w_job_byte = 8'hC0;
          2'd2:    w_job_byte = 8'h01;
          default: w_job_byte = 8'h80;
        endcase
      end
      (w_run & (r_post == 2'd0) & r_pend_v): begin
        w_job_v    = 1'b1;
        w_job_rs   = 1'b1;
        w_job_byte = r_pend;
        w_job_char = 1'b1;
      end
      default: ;
    endcase
  end

  // Per-state timer expiry.
  always_comb begin
    w_done = 1'b1;
    unique case (r_state)
      S_PWR:   w_done = (r_cnt == PWR_LAST);
      S_SETUP: w_done = (r_cnt == 22'd1);
      S_EHI:   w_done = (r_cnt == EHI_LAST);
      S_HOLD:  w_done = (r_cnt == 22'd1);
      S_GAP:   w_done = (r_cnt == GAP_LAST);
      S_WAIT:  w_done = (r_cnt == (r_clr ? CLR_LAST : CMD_LAST));
      default: w_done = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge Clock_100MHz) begin
    if (!Reset_n)
      r_state <= S_PWR;
    else
      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_PWR, S_WAIT, S_IDLE:
        if (w_done) w_next = w_job_v ? S_SETUP : S_IDLE;
      S_SETUP:
        if (w_done) w_next = S_EHI;
      S_EHI:
        if (w_done) w_next = S_HOLD;
      S_HOLD:
        if (w_done)
          w_next = (r_hi & ~r_single) ? S_GAP : S_WAIT;
      S_GAP:
        if (w_done) w_next = S_SETUP;
      default:
        w_next = S_PWR;
    endcase
  end

  assign w_launch = w_done & w_job_v
                  & ((r_state == S_PWR) | (r_state == S_WAIT)
                   | (r_state == S_IDLE));
  assign w_take = w_launch & w_job_char;

  // Output decode: bus driven only around the E strobe.
  always_comb begin
    w_act = (r_state == S_SETUP) | (r_state == S_EHI)
          | (r_state == S_HOLD);
    w_e   = (r_state == S_EHI);
    w_db  = 4'd0;
    w_rs  = 1'b0;
    if (w_act) begin
      w_db = r_hi ? r_byte[7:4] : r_byte[3:0];
      w_rs = r_rs;
    end
  end

  // Timer, byte latch, init progress and cursor tracking.
  always_ff @(posedge Clock_100MHz) begin
    if (!Reset_n) begin
      r_cnt    <= 22'd0;
      r_byte   <= 8'd0;
      r_rs     <= 1'b0;
      r_hi     <= 1'b0;
      r_single <= 1'b0;
      r_clr    <= 1'b0;
      r_step   <= 4'd0;
      r_post   <= 2'd0;
      r_cursor <= 5'd0;
    end else begin
      if (w_next != r_state || r_state == S_IDLE)
        r_cnt <= 22'd0;
      else
        r_cnt <= r_cnt + 22'd1;
      if (w_launch) begin
        r_byte   <= w_job_byte;
        r_rs     <= w_job_rs;
        r_single <= w_job_single;
        r_clr    <= (w_job_byte == 8'h01) & ~w_job_rs;
        r_hi     <= 1'b1;
        if (!r_step[3]) begin
          r_step <= r_step + 4'd1;
        end else if (r_post != 2'd0) begin
          r_post <= (r_post == 2'd2) ? 2'd3 : 2'd0;
        end else if (r_cursor == 5'd15) begin
          r_post   <= 2'd1;
          r_cursor <= 5'd16;
        end else if (r_cursor == 5'd31) begin
          r_post   <= 2'd2;
          r_cursor <= 5'd0;
        end else begin
          r_cursor <= r_cursor + 5'd1;
        end
      end else if (r_state == S_GAP && w_done) begin
        r_hi <= 1'b0;
      end
    end
  end

  // Registered LCD pins.
  always_ff @(posedge Clock_100MHz) begin
    if (!Reset_n) begin
      LCD_DB <= 4'd0;
      LCD_E  <= 1'b0;
      LCD_RS <= 1'b0;
    end else begin
      LCD_DB <= w_db;
      LCD_E  <= w_e;
      LCD_RS <= w_rs;
    end
  end

  assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_keyboard_to_lcd_top.sv
// Directed bench for keyboard_to_lcd_top.
// Shortened timing parameters keep the run small.
module tb_keyboard_to_lcd_top;

  localparam int CLK_HZ = 10_000_000;
  localparam int TO     = 2000;
  localparam int EH     = 4;
  localparam int CW     = 40;
  localparam int CLW    = 200;
  localparam int H      = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [3:0] db;
  logic       e;
  logic       rs;
  logic       rw;
  logic       caps;
  logic       shift;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  logic [4:0] q[$];
  int         last_w = 0;
  int         w_cnt = 0;
  int         stab = 0;
  int         min_setup = 1000;
  logic       e_prev = 1'b0;
  logic [4:0] prev_bus = 5'd0;

  always #5 clk = ~clk;

  keyboard_to_lcd_top #(
    .CLK_HZ           (CLK_HZ),
    .TIMEOUT_CYCLES   (TO),
    .E_HIGH_CYCLES    (EH),
    .CMD_WAIT_CYCLES  (CW),
    .CLEAR_WAIT_CYCLES(CLW)
  ) dut (
    .Clock_100MHz(clk),
    .Reset_n     (rst_n),
    .PS2_CLK     (ps2_clk),
    .PS2_DAT     (ps2_dat),
    .LCD_DB      (db),
    .LCD_E       (e),
    .LCD_RS      (rs),
    .LCD_RW      (rw),
    .Caps_Lock   (caps),
    .Shift_on    (shift)
  );

  // Capture {RS,DB} at every LCD_E rise; track E width and setup.
  always @(negedge clk) begin
    if ({rs, db} == prev_bus) stab++;
    else stab = 0;
    if (e && !e_prev) begin
      q.push_back({rs, db});
      if (stab < min_setup) min_setup = stab;
      w_cnt = 1;
    end else if (e) begin
      w_cnt++;
    end else if (e_prev) begin
      last_w = w_cnt;
    end
    prev_bus = {rs, db};
    e_prev   = e;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = f[i];
      cyc(H);
      ps2_clk = 1'b0;
      cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    cyc(H * 4);
  endtask

  task automatic send(input logic [7:0] c, input logic bad);
    logic [10:0] f;
    f = {1'b1, (~^c) ^ bad, c, 1'b0};
    send_bits(f, 11);
  endtask

  task automatic get_nib(output logic [4:0] v);
    int t;
    t = 0;
    while (q.size() == 0 && t < 2000) begin
      cyc(1);
      t++;
    end
    if (q.size() == 0) v = 5'bx;
    else v = q.pop_front();
  endtask

  task automatic exp_byte(input string tag,
                          input logic r,
                          input logic [7:0] b);
    logic [4:0] v;
    get_nib(v);
    chk({tag, "_hi"}, {27'd0, v}, {27'd0, r, b[7:4]});
    get_nib(v);
    chk({tag, "_lo"}, {27'd0, v}, {27'd0, r, b[3:0]});
  endtask

  logic [3:0] init_nib [12];
  logic [4:0] nv;
  logic [10:0] part;

  initial begin
    init_nib = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};

    cyc(10);
    chk("rst_db", {28'd0, db}, 32'd0);
    chk("rst_e", {31'd0, e}, 32'd0);
    chk("rst_rs", {31'd0, rs}, 32'd0);
    chk("rst_rw", {31'd0, rw}, 32'd0);
    chk("rst_caps", {31'd0, caps}, 32'd0);
    chk("rst_shift", {31'd0, shift}, 32'd0);
    rst_n = 1'b1;

    cyc(TO - 20);
    chk("no_e_in_pwr_wait", q.size(), 0);

    for (int i = 0; i < 12; i++) begin
      get_nib(nv);
      chk($sformatf("init%0d", i), {27'd0, nv},
          {27'd0, 1'b0, init_nib[i]});
    end
    chk("e_width", last_w, EH);

    send(8'h1C, 1'b0);
    exp_byte("char_a", 1'b1, 8'h61);

    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    cyc(300);
    chk("break_silent", q.size(), 0);

    send(8'h58, 1'b0);
    chk("caps_on", {31'd0, caps}, 32'd1);
    send(8'h1C, 1'b0);
    exp_byte("char_A", 1'b1, 8'h41);
    send(8'h58, 1'b0);
    chk("caps_off", {31'd0, caps}, 32'd0);

    send(8'h12, 1'b0);
    chk("shift_on", {31'd0, shift}, 32'd1);
    send(8'h16, 1'b0);
    exp_byte("char_bang", 1'b1, 8'h21);
    send(8'hF0, 1'b0);
    send(8'h12, 1'b0);
    chk("shift_off", {31'd0, shift}, 32'd0);

    for (int n = 4; n <= 32; n++) begin
      send(8'h16, 1'b0);
      exp_byte($sformatf("c%0d", n), 1'b1, 8'h31);
      if (n == 16) exp_byte("line2", 1'b0, 8'hC0);
      if (n == 32) begin
        exp_byte("wrap_clr", 1'b0, 8'h01);
        exp_byte("wrap_home", 1'b0, 8'h80);
      end
    end

    part = {1'b1, 1'b0, 8'h29, 1'b0};
    send_bits(part, 5);
    cyc(TO + 500);
    send(8'h29, 1'b0);
    exp_byte("space_after_to", 1'b1, 8'h20);
    cyc(300);
    chk("only_one_space", q.size(), 0);

`ifdef PS2_PARITY_CHECK_EN
    send(8'h1C, 1'b1);
    cyc(300);
    chk("bad_parity_drop", q.size(), 0);
`endif

    chk("rw_low", {31'd0, rw}, 32'd0);
    chk("setup_ge2", {31'd0, min_setup >= 2}, 32'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
